// File: rtl/fifo_mac_pkg.sv
`default_nettype none
// ============================================================================
// fifo_mac_pkg : shared types and width helpers for the FIFO MAC reader
// Revision     : 1.0
// ============================================================================
package fifo_mac_pkg;

    typedef enum logic [0:0] {
        ST_RUN = 1'b0,
        ST_OUT = 1'b1
    } state_t;

    // Wide enough that TAPS full-scale products can be summed without overflow.
    function automatic int calc_acc_w(input int width, input int coef_w, input int taps);
        return width + coef_w + $clog2(taps);
    endfunction

    // Counter width that can hold the value TAPS itself.
    function automatic int calc_cnt_w(input int taps);
        return $clog2(taps + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_mac_reader_mac_unit.sv
`default_nettype none
// ============================================================================
// mac_unit : registered unsigned multiply-accumulate, clear has priority
// Revision : 1.0
// ============================================================================
module mac_unit
    import fifo_mac_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int COEF_W = 4,
    parameter int TAPS   = 4,
    parameter int ACC_W  = calc_acc_w(WIDTH, COEF_W, TAPS)
) (
    input  logic              rclk,
    input  logic              reset,
    input  logic              clr,
    input  logic              en,
    input  logic [WIDTH-1:0]  a,
    input  logic [COEF_W-1:0] b,
    output logic [ACC_W-1:0]  acc
);

    localparam int c_PROD_W = WIDTH + COEF_W;

    logic [c_PROD_W-1:0] w_prod;
    logic [ACC_W-1:0]    w_prod_ext;
    logic [ACC_W-1:0]    r_acc;

    assign w_prod     = {{COEF_W{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    assign w_prod_ext = ACC_W'(w_prod);

    always_ff @(posedge rclk) begin
        if (!reset || clr) begin
            r_acc <= '0;
        end else if (en) begin
            r_acc <= r_acc + w_prod_ext;
        end
    end

    assign acc = r_acc;

endmodule
`default_nettype wire

// File: rtl/fifo_mac_reader.sv
`default_nettype none
// ============================================================================
// fifo_mac_reader : pops TAPS samples per frame from a FIFO read port and
//                   presents the coefficient-weighted sum on valid/ready
// Revision        : 1.0
// ============================================================================
module fifo_mac_reader
    import fifo_mac_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int COEF_W = 4,
    parameter int TAPS   = 4,
    parameter int ACC_W  = calc_acc_w(WIDTH, COEF_W, TAPS)
) (
    input  logic                   rclk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [TAPS*COEF_W-1:0] coef,
    input  logic                   empty,
    input  logic [WIDTH-1:0]       rd_data,
    output logic                   rd_en,
    output logic [ACC_W-1:0]       out_data,
    output logic                   out_valid,
    input  logic                   out_ready
);

    localparam int                 c_CNT_W = calc_cnt_w(TAPS);
    localparam logic [c_CNT_W-1:0] c_TAPS  = c_CNT_W'(TAPS);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(TAPS - 1);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_CNT_W-1:0]  r_issued;
    logic [c_CNT_W-1:0]  r_received;
    logic                r_dvalid;
    logic                r_out_valid;
    logic                w_rd_en;
    logic                w_accept;
    logic                w_last;
    logic [COEF_W-1:0]   w_coef_sel;
    logic [COEF_W-1:0]   w_coef_tap [TAPS];
    logic [ACC_W-1:0]    w_acc;

    generate
        for (genvar gi = 0; gi < TAPS; gi++) begin : g_coef
            assign w_coef_tap[gi] = coef[gi*COEF_W +: COEF_W];
        end
    endgenerate

    always_comb begin
        w_coef_sel = '0;
        for (int i = 0; i < TAPS; i++) begin
            if (r_received == c_CNT_W'(i)) begin
                w_coef_sel = w_coef_tap[i];
            end
        end
    end

    // rd_data arrives one cycle after each pop, so r_dvalid gates accumulation.
    always_comb begin
        w_state_nxt = r_state;
        w_rd_en     = 1'b0;
        w_accept    = 1'b0;
        w_last      = r_dvalid && (r_received == c_LAST);
        case (r_state)
            ST_RUN: begin
                w_rd_en = enable && !empty && (r_issued < c_TAPS);
                if (w_last) begin
                    w_state_nxt = ST_OUT;
                end
            end
            ST_OUT: begin
                w_accept = r_out_valid && out_ready;
                if (w_accept) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge rclk) begin
        if (!reset) begin
            r_state     <= ST_RUN;
            r_issued    <= '0;
            r_received  <= '0;
            r_dvalid    <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_dvalid <= w_rd_en;
            if (w_accept) begin
                r_issued    <= '0;
                r_received  <= '0;
                r_out_valid <= 1'b0;
            end else begin
                if (w_rd_en) begin
                    r_issued <= r_issued + c_ONE;
                end
                if (r_dvalid && (r_received < c_TAPS)) begin
                    r_received <= r_received + c_ONE;
                end
                if (w_last) begin
                    r_out_valid <= 1'b1;
                end
            end
        end
    end

    mac_unit #(
        .WIDTH  (WIDTH),
        .COEF_W (COEF_W),
        .TAPS   (TAPS),
        .ACC_W  (ACC_W)
    ) u_mac (
        .rclk  (rclk),
        .reset (reset),
        .clr   (w_accept),
        .en    (r_dvalid),
        .a     (rd_data),
        .b     (w_coef_sel),
        .acc   (w_acc)
    );

    // The accumulator holds the final sum for the whole OUT state.
    assign rd_en     = w_rd_en;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_valid ? w_acc : '0;

endmodule
`default_nettype wire

// File: tb/tb_fifo_mac_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_fifo_mac_reader : directed and randomized frames against a FIFO model
// Revision           : 1.0
// ============================================================================
module tb_fifo_mac_reader;

    localparam int WIDTH  = 4;
    localparam int COEF_W = 4;
    localparam int TAPS   = 4;
    localparam int ACC_W  = WIDTH + COEF_W + $clog2(TAPS);

    logic                   rclk      = 1'b0;
    logic                   reset     = 1'b0;
    logic                   enable    = 1'b0;
    logic [TAPS*COEF_W-1:0] coef      = '0;
    logic                   empty;
    logic [WIDTH-1:0]       rd_data   = '0;
    logic                   rd_en;
    logic [ACC_W-1:0]       out_data;
    logic                   out_valid;
    logic                   out_ready = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [WIDTH-1:0] mem [0:1023];
    int wr_ptr  = 0;
    int rd_ptr  = 0;
    int cyc     = 0;
    int rd_cnt  = 0;
    int last_rd = 0;

    always #5 rclk = ~rclk;

    assign empty = (wr_ptr == rd_ptr);

    fifo_mac_reader #(
        .WIDTH  (WIDTH),
        .COEF_W (COEF_W),
        .TAPS   (TAPS),
        .ACC_W  (ACC_W)
    ) dut (
        .rclk      (rclk),
        .reset     (reset),
        .enable    (enable),
        .coef      (coef),
        .empty     (empty),
        .rd_data   (rd_data),
        .rd_en     (rd_en),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    // Upstream FIFO model: data appears on rd_data the cycle after a pop.
    always @(posedge rclk) begin
        cyc = cyc + 1;
        if (rd_en) begin
            rd_cnt  = rd_cnt + 1;
            last_rd = cyc;
            n_checks++;
            if (empty) begin
                n_fail++;
                $display("FAIL rd_en_while_empty: rd_en=1 with empty=%0b, required empty=0", empty);
            end
            rd_data <= mem[rd_ptr];
            rd_ptr  <= rd_ptr + 1;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    task automatic push(input logic [WIDTH-1:0] v);
        mem[wr_ptr] = v;
        wr_ptr++;
    endtask

    task automatic wait_result(output logic [ACC_W-1:0] v, output bit ok);
        ok = 1'b0;
        v  = '0;
        for (int i = 0; i < 300; i++) begin
            @(negedge rclk);
            if (out_valid) begin
                v  = out_data;
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) tick();
        @(negedge rclk);
        n_checks++;
        if (rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %b expected 0", rd_en); end
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++;
        if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data: got %0d expected 0", out_data); end
        tick();
        reset  = 1'b1;
        enable = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [ACC_W-1:0] v;
        bit ok;
        int r0;
        coef      = {TAPS{4'd1}};
        out_ready = 1'b1;
        r0        = rd_cnt;
        for (int i = 1; i <= 4; i++) push(WIDTH'(i));
        wait_result(v, ok);
        n_checks++;
        if (!ok || v !== ACC_W'(10)) begin n_fail++; $display("FAIL basic_sum: got %0d (valid seen=%0b) expected 10", v, ok); end
        n_checks++;
        if (rd_cnt - r0 !== 4) begin n_fail++; $display("FAIL basic_rd_count: got %0d expected 4", rd_cnt - r0); end
        n_checks++;
        if (cyc - last_rd !== 1) begin n_fail++; $display("FAIL basic_latency: got %0d edges after last-pop edge expected 1", cyc - last_rd); end
        @(negedge rclk);
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_single_pulse: out_valid got %b expected 0", out_valid); end
        tick();
    endtask

    task automatic test_weighted();
        logic [ACC_W-1:0] v;
        bit ok;
        coef = {4'd4, 4'd3, 4'd2, 4'd1};
        for (int i = 1; i <= 4; i++) push(WIDTH'(i));
        wait_result(v, ok);
        n_checks++;
        if (!ok || v !== ACC_W'(30)) begin n_fail++; $display("FAIL weighted_sum: got %0d expected 30", v); end
        tick();
        coef = {TAPS{4'd15}};
        for (int i = 0; i < 4; i++) push(4'd15);
        wait_result(v, ok);
        n_checks++;
        if (!ok || v !== ACC_W'(900)) begin n_fail++; $display("FAIL full_scale_sum: got %0d expected 900", v); end
        tick();
    endtask

    task automatic test_empty_gap();
        logic [ACC_W-1:0] v;
        bit ok;
        int r0;
        int gap_rd;
        coef   = {4'd4, 4'd3, 4'd2, 4'd1};
        r0     = rd_cnt;
        gap_rd = 0;
        push(4'd1);
        push(4'd2);
        for (int i = 0; i < 20 && (rd_cnt - r0) < 2; i++) tick();
        for (int i = 0; i < 3; i++) begin
            @(negedge rclk);
            if (rd_en) gap_rd++;
            tick();
        end
        n_checks++;
        if (gap_rd !== 0) begin n_fail++; $display("FAIL gap_rd_en: got %0d pop cycles during gap expected 0", gap_rd); end
        push(4'd3);
        push(4'd4);
        wait_result(v, ok);
        n_checks++;
        if (!ok || v !== ACC_W'(30)) begin n_fail++; $display("FAIL gap_sum: got %0d expected 30", v); end
        n_checks++;
        if (rd_cnt - r0 !== 4) begin n_fail++; $display("FAIL gap_rd_count: got %0d expected 4", rd_cnt - r0); end
        tick();
    endtask

    task automatic test_backpressure();
        logic [ACC_W-1:0] v;
        bit ok;
        coef      = {4'd4, 4'd3, 4'd2, 4'd1};
        out_ready = 1'b0;
        for (int f = 0; f < 2; f++)
            for (int i = 1; i <= 4; i++) push(WIDTH'(i));
        wait_result(v, ok);
        n_checks++;
        if (!ok || v !== ACC_W'(30)) begin n_fail++; $display("FAIL bp_sum: got %0d expected 30", v); end
        for (int i = 0; i < 5; i++) begin
            tick();
            @(negedge rclk);
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== ACC_W'(30) || rd_en !== 1'b0)
                begin n_fail++; $display("FAIL bp_hold: valid=%b data=%0d rd_en=%b expected valid=1 data=30 rd_en=0", out_valid, out_data, rd_en); end
        end
        tick();
        out_ready = 1'b1;
        @(negedge rclk);
        @(negedge rclk);
        n_checks++;
        if (out_valid !== 1'b0 || rd_en !== 1'b1)
            begin n_fail++; $display("FAIL bp_restart: valid=%b rd_en=%b expected valid=0 rd_en=1", out_valid, rd_en); end
        wait_result(v, ok);
        n_checks++;
        if (!ok || v !== ACC_W'(30)) begin n_fail++; $display("FAIL bp_next_sum: got %0d expected 30", v); end
        tick();
    endtask

    task automatic test_midframe_reset();
        logic [ACC_W-1:0] v;
        bit ok;
        int r0;
        coef      = {4'd4, 4'd3, 4'd2, 4'd1};
        out_ready = 1'b1;
        r0        = rd_cnt;
        push(4'd1);
        push(4'd2);
        for (int i = 0; i < 20 && (rd_cnt - r0) < 2; i++) tick();
        repeat (3) tick();
        reset = 1'b0;
        @(negedge rclk);
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || rd_en !== 1'b0)
            begin n_fail++; $display("FAIL midreset_outputs: valid=%b data=%0d rd_en=%b expected all 0", out_valid, out_data, rd_en); end
        tick();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) push(4'd2);
        wait_result(v, ok);
        n_checks++;
        if (!ok || v !== ACC_W'(20)) begin n_fail++; $display("FAIL midreset_sum: got %0d expected 20", v); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [ACC_W-1:0] v;
        bit ok;
        int r0;
        coef      = {TAPS{4'd1}};
        out_ready = 1'b1;
        r0        = rd_cnt;
        for (int i = 1; i <= 8; i++) push(WIDTH'(i));
        wait_result(v, ok);
        n_checks++;
        if (!ok || v !== ACC_W'(10)) begin n_fail++; $display("FAIL b2b_first: got %0d expected 10", v); end
        wait_result(v, ok);
        n_checks++;
        if (!ok || v !== ACC_W'(26)) begin n_fail++; $display("FAIL b2b_second: got %0d expected 26", v); end
        n_checks++;
        if (rd_cnt - r0 !== 8) begin n_fail++; $display("FAIL b2b_rd_count: got %0d expected 8", rd_cnt - r0); end
        tick();
    endtask

    task automatic test_random();
        for (int b = 0; b < 6; b++) begin
            int ct [TAPS];
            int d [3*TAPS];
            int exp_v [3];
            logic [ACC_W-1:0] obs [3];
            int got;
            for (int i = 0; i < TAPS; i++) begin
                ct[i] = (b == 0) ? 15 : int'($urandom_range(0, 15));
                coef[i*COEF_W +: COEF_W] = COEF_W'(ct[i]);
            end
            for (int k = 0; k < 3*TAPS; k++) d[k] = (b == 0) ? 15 : int'($urandom_range(0, 15));
            for (int f = 0; f < 3; f++) begin
                exp_v[f] = 0;
                for (int i = 0; i < TAPS; i++) exp_v[f] += d[f*TAPS + i] * ct[i];
            end
            got = 0;
            fork
                begin
                    for (int k = 0; k < 3*TAPS; k++) begin
                        int n;
                        n = int'($urandom_range(0, 2));
                        for (int j = 0; j < n; j++) begin
                            enable = ($urandom_range(0, 3) != 0);
                            tick();
                        end
                        push(WIDTH'(d[k]));
                    end
                    repeat (3) begin
                        enable = ($urandom_range(0, 1) != 0);
                        tick();
                    end
                    enable = 1'b1;
                end
                begin
                    for (int c = 0; c < 800 && got < 3; c++) begin
                        @(negedge rclk);
                        if (out_valid && out_ready) begin
                            obs[got] = out_data;
                            got++;
                        end
                        @(posedge rclk);
                        #1;
                        out_ready = ($urandom_range(0, 1) != 0);
                    end
                end
            join
            n_checks++;
            if (got !== 3) begin n_fail++; $display("FAIL rand_count batch %0d: got %0d results expected 3", b, got); end
            for (int f = 0; f < 3; f++) begin
                if (f < got) begin
                    n_checks++;
                    if (obs[f] !== ACC_W'(exp_v[f]))
                        begin n_fail++; $display("FAIL rand_sum batch %0d frame %0d: got %0d expected %0d", b, f, obs[f], exp_v[f]); end
                end
            end
            out_ready = 1'b1;
            @(negedge rclk);
            n_checks++;
            if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rand_extra batch %0d: out_valid got %b expected 0", b, out_valid); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_weighted();
        test_empty_gap();
        test_backpressure();
        test_midframe_reset();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
